// File: rtl/fetch_decode_skid_register_if.sv
// Fetch/decode handshake bundle for the fetch->decode skid register.
// slave: the pipeline register itself; master: the surrounding fetch/decode logic.
interface fetch_decode_skid_register_if #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and ready never depends combinationally on the far side's ready.
    logic               flush_i;
    logic               f_valid_i;
    logic               f_ready_o;
    logic [INSTR_W-1:0] f_instruction_i;
    logic [PC_W-1:0]    f_pc_i;
    logic               d_valid_o;
    logic               d_ready_i;
    logic [INSTR_W-1:0] fd_instruction_o;
    logic [PC_W-1:0]    fd_pc_o;

    modport slave (
        input  flush_i, f_valid_i, f_instruction_i, f_pc_i, d_ready_i,
        output f_ready_o, d_valid_o, fd_instruction_o, fd_pc_o
    );

    modport master (
        output flush_i, f_valid_i, f_instruction_i, f_pc_i, d_ready_i,
        input  f_ready_o, d_valid_o, fd_instruction_o, fd_pc_o
    );
endinterface

// File: rtl/fetch_decode_skid_register.sv
// Fetch->decode pipeline register with a 2-entry skid buffer, flush, and NOP insertion.
// Optional FD_STALL_COUNT_EN adds stall_cnt_o, a saturating count of decode stall cycles.
module fetch_decode_skid_register #(
    parameter int                INSTR_W   = 32,
    parameter int                PC_W      = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic clk_i,
    input  logic rst_i,
`ifdef FD_STALL_COUNT_EN
    output logic [15:0] stall_cnt_o,
`endif
    fetch_decode_skid_register_if.slave bus
);
    logic               r_m_valid;
    logic [INSTR_W-1:0] r_m_instr;
    logic [PC_W-1:0]    r_m_pc;
    logic               r_s_valid;
    logic [INSTR_W-1:0] r_s_instr;
    logic [PC_W-1:0]    r_s_pc;

    logic w_accept;
    logic w_drain;

    // Ready comes only from registered skid state, so decode back-pressure never reaches fetch combinationally.
    assign bus.f_ready_o        = !r_s_valid && !rst_i;
    assign bus.d_valid_o        = r_m_valid;
    assign bus.fd_instruction_o = r_m_instr;
    assign bus.fd_pc_o          = r_m_pc;

    assign w_accept = bus.f_valid_i && bus.f_ready_o;
    assign w_drain  = r_m_valid && bus.d_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || bus.flush_i) begin
            r_m_valid <= 1'b0;
            r_m_instr <= NOP_INSTR;
            r_m_pc    <= '0;
            r_s_valid <= 1'b0;
            r_s_instr <= NOP_INSTR;
            r_s_pc    <= '0;
        end else if (!r_m_valid || w_drain) begin
            if (r_s_valid) begin
                // Skid refills main; fetch was already stalled so no accept competes here.
                r_m_valid <= 1'b1;
                r_m_instr <= r_s_instr;
                r_m_pc    <= r_s_pc;
                r_s_valid <= 1'b0;
                r_s_instr <= NOP_INSTR;
            end else if (w_accept) begin
                r_m_valid <= 1'b1;
                r_m_instr <= bus.f_instruction_i;
                r_m_pc    <= bus.f_pc_i;
            end else begin
                r_m_valid <= 1'b0;
                r_m_instr <= NOP_INSTR;
            end
        end else if (w_accept) begin
            r_s_valid <= 1'b1;
            r_s_instr <= bus.f_instruction_i;
            r_s_pc    <= bus.f_pc_i;
        end
    end

`ifdef FD_STALL_COUNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (r_m_valid && !bus.d_ready_i && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif
endmodule

// File: doc/fetch_decode_skid_register.md
Name: fetch_decode_skid_register

Overview:
- Parametrised fetch→decode pipeline register with a valid/ready handshake, a 2-entry skid buffer, and a flush input.
- Decouples the fetch stage from decode back-pressure without a combinational ready path. Sustains one instruction per cycle.
- Invalid or flushed slots present a NOP to decode.
- Sits between the fetch stage and the decoder.

Parameters:
- INSTR_W, 32, instruction width in bits.
- PC_W, 32, program counter width in bits.
- NOP_INSTR, 32'h00000013, encoding driven on fd_instruction_o when the stage holds no valid instruction (RV32I addi x0,x0,0). Width INSTR_W.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- flush_i  input  1  discard all held and incoming instructions (branch/jump redirect).
- f_valid_i  input  1  fetch presents a valid instruction.
- f_ready_o  output  1  stage can accept an instruction this cycle.
- f_instruction_i  input  INSTR_W  instruction from fetch.
- f_pc_i  input  PC_W  PC from fetch.
- d_valid_o  output  1  fd_* outputs carry a valid instruction.
- d_ready_i  input  1  decode consumes the presented instruction this cycle.
- fd_instruction_o  output  INSTR_W  instruction to decode.
- fd_pc_o  output  PC_W  PC to decode.

Behaviour:
- State: main slot (m_valid, m_instr, m_pc) drives outputs directly; skid slot (s_valid, s_instr, s_pc).
- Accept = f_valid_i & f_ready_o. Drain = d_valid_o & d_ready_i.
- f_ready_o = !s_valid & !rst_i. Registered-only dependency; no combinational path from d_ready_i.
- d_valid_o = m_valid.
- fd_instruction_o = m_instr; fd_pc_o = m_pc.
- Whenever m_valid is 0, m_instr holds NOP_INSTR.
- Reset (rst_i=1 at edge):
  - m_valid=0, s_valid=0.
  - m_instr=NOP_INSTR, m_pc=0; s_instr=NOP_INSTR, s_pc=0.
  - Outputs after the edge: d_valid_o=0, fd_instruction_o=NOP_INSTR, fd_pc_o=0, f_ready_o=1 once rst_i is low.
  - Accept during reset is impossible because f_ready_o=0.
  - Reset mid-transfer drops both slots.
- Flush (rst_i=0, flush_i=1): same state result as reset, except f_ready_o stays governed by s_valid (becomes 1 next cycle).
  - An instruction accepted in the flush cycle is discarded.
  - A drain in the flush cycle is still a valid transfer to decode.
  - Flush has priority over all other updates.
- Normal update, no flush:
  - main empty or draining, skid empty: on accept, main←input (m_valid=1); else m_valid=0, m_instr=NOP_INSTR.
  - main full, not draining, accept: skid←input (s_valid=1); f_ready_o=0 from next cycle.
  - main draining, skid full: main←skid, s_valid=0; f_ready_o=1 next cycle. No accept is possible this cycle (f_ready_o=0).
  - main full, not draining, no accept: hold.
- Latency: 1 cycle from accept to d_valid_o when empty. Throughput: 1 per cycle with d_ready_i held high.
- Ordering: strictly FIFO. No instruction is lost or duplicated except by flush or reset.
- Held outputs remain stable while d_valid_o=1 and d_ready_i=0.

Optional Feature:
- Macro: FD_STALL_COUNT_EN.
- Defined:
  - Extra port stall_cnt_o, output, 16 bits.
  - Increments each cycle with d_valid_o=1 and d_ready_i=0; saturates at 16'hFFFF.
  - Cleared by rst_i; not cleared by flush_i.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset with inputs active (f_valid_i=1, pc=0x100) → d_valid_o=0, fd_instruction_o=0x00000013, fd_pc_o=0, f_ready_o=0 during reset and 1 after.
- Stream pc 0x0,0x4,0x8 with d_ready_i=1 → each appears one cycle later in order; f_ready_o stays 1.
- Hold d_ready_i=0, then push 0x10 and 0x14 → 0x10 held on outputs; f_ready_o=0 after the second accept. Release d_ready_i → 0x10 then 0x14 on consecutive cycles; f_ready_o=1 the cycle after 0x14 moves to main.
- Both slots full, flush_i=1 with f_valid_i=1 (pc 0x20) → next cycle d_valid_o=0, fd_instruction_o=NOP, f_ready_o=1; 0x20 never appears.
- Random f_valid_i/d_ready_i for 10k cycles vs. a scoreboard queue → exact order, no loss or duplication, outputs stable under stall.
- FD_STALL_COUNT_EN defined, 5 stall cycles then 1 drain → stall_cnt_o=5; flush keeps 5; reset clears to 0.
